aes_round_stage: RTL and testbench

AES_ROUND_STAGE -- requirements
Module: aes_round_stage

---
 rtl/aes_round_if.sv | 25 ++
 rtl/aes_round_stage.sv | 170 +++++++++++++++++
 tb/tb_aes_round_stage.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_if.sv
// AES round-stage handshake bundle: SubBytes/round-key input side and round-result output side.
interface aes_round_if;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned IDX_W  = 4;

    logic [DATA_W-1:0] sb_data;
    logic [DATA_W-1:0] round_key;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [IDX_W-1:0]  round_idx;

    modport master (
        output sb_data, round_key, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, round_idx
    );

    modport slave (
        input  sb_data, round_key, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, round_idx
    );
endinterface

// File: rtl/aes_round_stage.sv
// One AES encryption round after SubBytes: ShiftRows, MixColumns (skipped in round 10), AddRoundKey.
// Define AES_ROUND_SKID_BUFFER_EN to add a skid entry and a fully registered in_ready.
module aes_round_stage (
    input  logic         clk,
    input  logic         rst_n,
    aes_round_if.slave   bus
);
    localparam int unsigned DATA_W     = 128;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned LAST_ROUND = 10;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i of the state sits at bits [127-8i -: 8]; row = i%4, column = i/4.
    function automatic logic [DATA_W-1:0] shift_rows(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] mix_columns(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    occ_t              state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [IDX_W-1:0]  round_q, round_d;

    logic              push, pop, is_last;
    logic [DATA_W-1:0] sr_data, mc_data, result;

`ifdef AES_ROUND_SKID_BUFFER_EN
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              skid_last_q, skid_last_d;
    logic              in_ready_q, in_ready_d;

    assign bus.in_ready = in_ready_q;
`else
    assign bus.in_ready = !out_valid_q || bus.out_ready;
`endif

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = out_valid_q && bus.out_ready;

    // Round datapath feeds only the result registers.
    assign is_last = (round_q == IDX_W'(LAST_ROUND));
    assign sr_data = shift_rows(bus.sb_data);
    assign mc_data = mix_columns(sr_data);
    assign result  = (is_last ? sr_data : mc_data) ^ bus.round_key;

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            round_q     <= IDX_W'(1);
`ifdef AES_ROUND_SKID_BUFFER_EN
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
            in_ready_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            round_q     <= round_d;
`ifdef AES_ROUND_SKID_BUFFER_EN
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
            in_ready_q  <= in_ready_d;
`endif
        end
    end

    // Occupancy, round counter and result steering.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        round_d    = round_q;
`ifdef AES_ROUND_SKID_BUFFER_EN
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
`endif

        if (push) begin
            round_d = is_last ? IDX_W'(1) : round_q + IDX_W'(1);
        end

        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    out_data_d = result;
                    out_last_d = is_last;
                    state_d    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push) begin
                    if (pop) begin
                        out_data_d = result;
                        out_last_d = is_last;
                    end
`ifdef AES_ROUND_SKID_BUFFER_EN
                    else begin
                        skid_data_d = result;
                        skid_last_d = is_last;
                        state_d     = ST_TWO;
                    end
`endif
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
`ifdef AES_ROUND_SKID_BUFFER_EN
            ST_TWO: begin
                // in_ready is low here, so only a drain of the output entry can occur.
                if (pop) begin
                    out_data_d = skid_data_q;
                    out_last_d = skid_last_q;
                    state_d    = ST_ONE;
                end
            end
`endif
            default: state_d = ST_EMPTY;
        endcase

        out_valid_d = (state_d != ST_EMPTY);
`ifdef AES_ROUND_SKID_BUFFER_EN
        in_ready_d  = (state_d != ST_TWO);
`endif
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.round_idx = round_q;

endmodule

// File: tb/tb_aes_round_stage.sv
// Randomized self-checking bench for aes_round_stage against a byte-array AES round model.
module tb_aes_round_stage;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    aes_round_if bus ();

    aes_round_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] V1_SB  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] V1_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] V1_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] V10_SB  = 128'he9098972cb31075f3d327d94af2e2cb5;
    localparam logic [127:0] V10_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] V10_OUT = 128'h3925841d02dc09fbdc118597196a0b32;

    // Expected results in order: {last, data}.
    logic [128:0] exp_q[$];
    int           model_round;
    int           n_push;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", tag, act, exp);
        end
    endtask

    // Generic GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] sb, input logic [127:0] key,
                                               input logic last);
        logic [7:0] st[16];
        logic [7:0] sr[16];
        logic [7:0] mc[16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) st[i] = sb[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) sr[r+4*c] = st[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                mc[r+4*c] = gmul(8'h02, sr[r+4*c]) ^ gmul(8'h03, sr[(r+1)%4+4*c])
                          ^ sr[(r+2)%4+4*c] ^ sr[(r+3)%4+4*c];
        for (int i = 0; i < 16; i++)
            res[127-8*i -: 8] = (last ? sr[i] : mc[i]) ^ key[127-8*i -: 8];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock cycle: drive, check DUT against the model, advance the model, idle inputs after the edge.
    task automatic cycle(input logic iv, input logic [127:0] sb, input logic [127:0] key,
                         input logic ordy);
        logic model_ready;
        logic is_last;
        logic [128:0] front;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.sb_data   = sb;
        bus.round_key = key;
        bus.out_ready = ordy;
        #1;
`ifdef AES_ROUND_SKID_BUFFER_EN
        model_ready = (exp_q.size() < 2);
`else
        model_ready = (exp_q.size() == 0) || ordy;
`endif
        check("round_idx", 128'(bus.round_idx), 128'(model_round));
        check("out_valid", 128'(bus.out_valid), 128'(exp_q.size() != 0));
        check("in_ready", 128'(bus.in_ready), 128'(model_ready));
        if (exp_q.size() != 0) begin
            front = exp_q[0];
            check("out_data", bus.out_data, front[127:0]);
            check("out_last", 128'(bus.out_last), 128'(front[128]));
            if (ordy) void'(exp_q.pop_front());
        end
        if (iv && model_ready) begin
            is_last = (model_round == 10);
            exp_q.push_back({is_last, ref_round(sb, key, is_last)});
            model_round = is_last ? 1 : model_round + 1;
            n_push++;
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic check_front(input string tag, input logic [127:0] data, input logic last);
        @(negedge clk);
        #1;
        check({tag, "_valid"}, 128'(bus.out_valid), 128'(1));
        check({tag, "_data"}, bus.out_data, data);
        check({tag, "_last"}, 128'(bus.out_last), 128'(last));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
        check({tag, "_out_last"}, 128'(bus.out_last), 128'(0));
        check({tag, "_out_data"}, bus.out_data, 128'(0));
        check({tag, "_round_idx"}, 128'(bus.round_idx), 128'(1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check_reset_values("rst");
        exp_q.delete();
        model_round = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    endtask

    initial begin
        int accepted;
        int exp_bp;
        checks        = 0;
        failures      = 0;
        n_push        = 0;
        model_round   = 1;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.sb_data   = '0;
        bus.round_key = '0;

        // Known-answer rounds 1 and 10.
        do_reset();
        cycle(1'b1, V1_SB, V1_KEY, 1'b1);
        check_front("fips_r1", V1_OUT, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, rand128(), rand128(), 1'b1);
        cycle(1'b1, V10_SB, V10_KEY, 1'b1);
        check_front("fips_r10", V10_OUT, 1'b1);
        check("fips_r10_round_idx", 128'(bus.round_idx), 128'(1));
        repeat (3) cycle(1'b0, '0, '0, 1'b1);

        // Back-pressure: consumer stalled for 5 cycles with a continuous producer.
        do_reset();
        accepted = n_push;
        repeat (5) cycle(1'b1, rand128(), rand128(), 1'b0);
        accepted = n_push - accepted;
`ifdef AES_ROUND_SKID_BUFFER_EN
        exp_bp = 2;
`else
        exp_bp = 1;
`endif
        check("bp_round_idx", 128'(bus.round_idx), 128'(1 + exp_bp));
        check("bp_accepted", 128'(accepted), 128'(exp_bp));
        repeat (4) cycle(1'b0, '0, '0, 1'b1);

        // Streaming: 20 back-to-back transfers, out_last on results 10 and 20.
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, rand128(), rand128(), 1'b1);
        repeat (3) cycle(1'b0, '0, '0, 1'b1);

        // Reset while round 4 is held on the output.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, rand128(), rand128(), 1'b1);
        @(negedge clk);
        check("mid_valid_before", 128'(bus.out_valid), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_rst");
        exp_q.delete();
        model_round = 1;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, V1_SB, V1_KEY, 1'b0);
        check_front("post_rst_r1", V1_OUT, 1'b0);
        repeat (3) cycle(1'b0, '0, '0, 1'b1);

        // Random handshakes on both sides.
        do_reset();
        for (int i = 0; i < 1000; i++)
            cycle(1'($urandom_range(0, 1)), rand128(), rand128(), 1'($urandom_range(0, 1)));
        repeat (4) cycle(1'b0, '0, '0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
